// File: rtl/image_sequencer.sv
// image_sequencer: stimulus and scoring engine for the MNIST CNN pipeline.
// Holds NUM_IMG images and their labels in on-chip RAM. For each image it
// flushes the downstream pipeline, streams the pixels in raster order, waits
// for the comparator decision (or a timeout) and scores it against the label.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   pix_we/pix_waddr/pix_wdata    pixel RAM write port (image*NPIX + pixel)
//   lbl_we/lbl_waddr/lbl_wdata    label RAM write port
//   start, mode, img_sel          run request (single image or whole batch)
//   clear_stats                   zero the statistics counters
//   dec_valid, decision           comparator result
//   core_rst_n                    active-low reset to the CNN pipeline
//   pix_valid, pix_data           pixel stream into conv1
//   busy, done                    run status, done is a one-cycle pulse
//   last_decision, last_hit       result of the most recently scored image
//   hit_cnt, img_cnt, timeout_cnt saturating statistics
module image_sequencer #(
  parameter int unsigned IMG_W      = 28,
  parameter int unsigned IMG_H      = 28,
  parameter int unsigned PIX_BITS   = 8,
  parameter int unsigned NUM_IMG    = 4,
  parameter int unsigned LABEL_BITS = 4,
  parameter int unsigned FLUSH_CYC  = 2,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned CNT_BITS   = 16,
  localparam int unsigned NPIX = IMG_W * IMG_H,
  localparam int unsigned PA   = (NUM_IMG * NPIX > 1) ? $clog2(NUM_IMG * NPIX) : 1,
  localparam int unsigned IA   = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_we,
  input  logic [PA-1:0]         pix_waddr,
  input  logic [PIX_BITS-1:0]   pix_wdata,
  input  logic                  lbl_we,
  input  logic [IA-1:0]         lbl_waddr,
  input  logic [LABEL_BITS-1:0] lbl_wdata,
  input  logic                  start,
  input  logic                  mode,
  input  logic [IA-1:0]         img_sel,
  input  logic                  clear_stats,
  input  logic                  dec_valid,
  input  logic [LABEL_BITS-1:0] decision,
  output logic                  core_rst_n,
  output logic                  pix_valid,
  output logic [PIX_BITS-1:0]   pix_data,
  output logic                  busy,
  output logic                  done,
  output logic [LABEL_BITS-1:0] last_decision,
  output logic                  last_hit,
  output logic [CNT_BITS-1:0]   hit_cnt,
  output logic [CNT_BITS-1:0]   img_cnt,
  output logic [CNT_BITS-1:0]   timeout_cnt
);

  localparam int unsigned IW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned FW   = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam int unsigned TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned NLBL = 1 << IA;

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_STREAM, S_WAIT, S_SCORE, S_DONE
  } state_t;

  state_t                state;
  logic                  mode_q;
  logic [IA-1:0]         cur_img;
  logic [IW-1:0]         idx;
  logic [FW-1:0]         flush_cnt;
  logic [TW-1:0]         timer;
  logic [LABEL_BITS-1:0] dec_q;
  logic                  timed_out;

  logic [PIX_BITS-1:0]   pix_mem [NUM_IMG*NPIX];
  logic [LABEL_BITS-1:0] lbl_mem [NLBL];

  logic [PA-1:0]         rd_addr;
  logic                  hit;
  logic                  last_img;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  // Read address and scoring terms
  always_comb begin
    rd_addr  = PA'(cur_img) * PA'(NPIX) + PA'(idx);
    hit      = (dec_q == lbl_mem[cur_img]) && !timed_out;
    last_img = (cur_img == IA'(NUM_IMG - 1));
  end

  // RAM write ports; contents survive reset
  always_ff @(posedge clk) begin
    if (pix_we) pix_mem[pix_waddr] <= pix_wdata;
    if (lbl_we) lbl_mem[lbl_waddr] <= lbl_wdata;
  end

  // Sequencer FSM, pixel read register and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      mode_q        <= 1'b0;
      cur_img       <= '0;
      idx           <= '0;
      flush_cnt     <= '0;
      timer         <= '0;
      dec_q         <= '0;
      timed_out     <= 1'b0;
      core_rst_n    <= 1'b0;
      pix_valid     <= 1'b0;
      pix_data      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      last_decision <= '0;
      last_hit      <= 1'b0;
      hit_cnt       <= '0;
      img_cnt       <= '0;
      timeout_cnt   <= '0;
    end else begin
      done      <= 1'b0;
      pix_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          core_rst_n <= 1'b1;
          if (start) begin
            mode_q     <= mode;
            cur_img    <= mode ? '0 : img_sel;
            flush_cnt  <= '0;
            core_rst_n <= 1'b0;
            busy       <= 1'b1;
            state      <= S_FLUSH;
          end
        end

        S_FLUSH: begin
          idx <= '0;
          if (flush_cnt == FW'(FLUSH_CYC - 1)) begin
            core_rst_n <= 1'b1;
            state      <= S_STREAM;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end

        // One read per cycle; data and valid appear one cycle later
        S_STREAM: begin
          pix_valid <= 1'b1;
          pix_data  <= pix_mem[rd_addr];
          if (idx == IW'(NPIX - 1)) begin
            timer <= '0;
            state <= S_WAIT;
          end else begin
            idx <= idx + IW'(1);
          end
        end

        // A real decision wins over a timeout expiring on the same edge
        S_WAIT: begin
          if (dec_valid) begin
            dec_q     <= decision;
            timed_out <= 1'b0;
            state     <= S_SCORE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            timed_out <= 1'b1;
            state     <= S_SCORE;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_SCORE: begin
          if (!timed_out) last_decision <= dec_q;
          last_hit <= hit;
          if (mode_q && !last_img) begin
            cur_img    <= cur_img + IA'(1);
            flush_cnt  <= '0;
            core_rst_n <= 1'b0;
            state      <= S_FLUSH;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase

      // Statistics: clear wins over a same-cycle score
      if (clear_stats) begin
        hit_cnt     <= '0;
        img_cnt     <= '0;
        timeout_cnt <= '0;
      end else if (state == S_SCORE) begin
        img_cnt <= sat_inc(img_cnt);
        if (hit)       hit_cnt     <= sat_inc(hit_cnt);
        if (timed_out) timeout_cnt <= sat_inc(timeout_cnt);
      end
    end
  end

endmodule

// File: doc/image_sequencer.md
# image_sequencer

Synthesizable stimulus and scoring engine for the MNIST CNN pipeline (conv1 → maxpool → conv2 → maxpool → fully connected → comparator). It holds up to NUM_IMG images and their labels in on-chip RAM. It flushes the pipeline with a per-image reset, streams one image raster-order into the conv1 input, waits for the comparator decision, and scores it against the label. It generalises single-image, fixed-784-pixel streaming to parametrised image size, image count, single/batch mode, timeout detection and hit counting.

## Interface
Parameters:
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- PIX_BITS, 8, pixel width
- NUM_IMG, 4, images held in buffer (≥1)
- LABEL_BITS, 4, label/decision width
- FLUSH_CYC, 2, cycles core_rst_n held low before each image (≥1)
- TIMEOUT, 4096, max cycles waiting for dec_valid after last pixel
- CNT_BITS, 16, width of statistics counters
- Derived: NPIX = IMG_W*IMG_H; PA = $clog2(NUM_IMG*NPIX); IA = max(1,$clog2(NUM_IMG))

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- pix_we  in  1  pixel RAM write enable
- pix_waddr  in  PA  write address (image*NPIX + pixel index)
- pix_wdata  in  PIX_BITS  write data
- lbl_we  in  1  label write enable
- lbl_waddr  in  IA  label index
- lbl_wdata  in  LABEL_BITS  label value
- start  in  1  begin run (sampled only in IDLE)
- mode  in  1  0 = single image img_sel, 1 = batch 0..NUM_IMG-1 (sampled with start)
- img_sel  in  IA  image for mode 0 (sampled with start)
- clear_stats  in  1  zero hit_cnt, img_cnt, timeout_cnt
- dec_valid  in  1  comparator valid_out
- decision  in  LABEL_BITS  comparator decision
- core_rst_n  out  1  active-low reset to the downstream CNN pipeline
- pix_valid  out  1  pix_data carries a pixel
- pix_data  out  PIX_BITS  pixel to conv1 data_in
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the run completes
- last_decision  out  LABEL_BITS  decision of the most recent scored image
- last_hit  out  1  most recent image matched its label
- hit_cnt, img_cnt, timeout_cnt  out  CNT_BITS each  statistics

## Operation
- FSM states: IDLE → FLUSH → STREAM → WAIT → SCORE → (FLUSH for the next batch image | DONE) → IDLE.
- IDLE: core_rst_n=1, pix_valid=0. On start=1, latch mode/img_sel, set cur_img (img_sel or 0), go to FLUSH.
- FLUSH: core_rst_n=0 for exactly FLUSH_CYC cycles. pix index is reset to 0.
- STREAM: issue RAM reads at cur_img*NPIX + idx for idx 0..NPIX-1, one per cycle. RAM read is synchronous with 1-cycle latency. pix_valid is high for exactly NPIX consecutive cycles, aligned with pix_data. pix_data holds its last value when pix_valid=0.
- WAIT: wait for dec_valid. If a timer reaches TIMEOUT cycles with no dec_valid, score the image as a miss and increment timeout_cnt.
- SCORE (1 cycle): last_decision=decision (unchanged on timeout); last_hit=(decision==label[cur_img]) & ~timeout; img_cnt+=1; hit_cnt+=last_hit.
  - Mode 1 and cur_img<NUM_IMG-1: cur_img+=1, go to FLUSH.
  - Otherwise go to DONE.
- DONE (1 cycle): done=1, go to IDLE.
- dec_valid outside WAIT is ignored.
- start while busy is ignored.
- Counters saturate at all-ones; they do not wrap.
- clear_stats has priority over an increment in the same cycle.
- RAM writes are accepted in any state. A same-cycle read/write to the same address returns old data. Label writes during a run take effect at the next SCORE.
- img_sel ≥ NUM_IMG: image index wraps modulo 2^IA. Behaviour is undefined if that index is unpopulated; no error flag.

## Timing
- Reset values (rst=1, synchronous):
  - State IDLE; core_rst_n=0 while rst is high, 1 in the first cycle after.
  - pix_valid=0, pix_data=0, busy=0, done=0, last_decision=0, last_hit=0, all counters 0.
  - RAM contents are not reset.
- rst asserted mid-run aborts immediately. No done pulse; counters clear.
- start sampled at edge k:
  - core_rst_n low cycles k+1..k+FLUSH_CYC.
  - First pix_valid in cycle k+FLUSH_CYC+2.
  - Last pix_valid in cycle k+FLUSH_CYC+NPIX+1.
- dec_valid at edge m in WAIT: SCORE in cycle m+1, counters update at edge m+1, done at cycle m+2 (single mode).
- Back-to-back batch images: next FLUSH begins the cycle after SCORE. There are no gaps beyond FLUSH and the 1-cycle read latency.

## Test plan
- Single image, default params: load 784 pixels of digit 9 plus label 9, start with mode 0. Expect:
  - core_rst_n low exactly 2 cycles.
  - 784 contiguous pix_valid cycles, with pix_data equal to the RAM contents in order.
  - Model dec_valid with decision=9 → last_hit=1, hit_cnt=1, img_cnt=1, done pulse once.
- Batch mode with NUM_IMG=4, labels 0,1,2,3, decisions 0,1,5,3 → 4 flushes, img_cnt=4, hit_cnt=3, single done.
- Timeout with TIMEOUT=16 and no dec_valid → SCORE 16 cycles after the last pixel, timeout_cnt=1, last_hit=0, last_decision unchanged.
- Stray dec_valid during STREAM plus start during busy → both ignored; pixel count and scores unaffected.
- rst pulsed at pixel 300 → pix_valid=0 and counters=0 next cycle, no done. A fresh start replays from pixel 0.
- CNT_BITS=2 saturation: 5 hits → hit_cnt=3. clear_stats coinciding with SCORE → counters 0.
